// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM state type and the divide-by-zero quotient constant
// for the sequential non-restoring divider.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   // All-ones pattern of the requested width (width <= 64).
   function automatic logic [63:0] dbz_quotient(input int width);
      logic [63:0] q;
      q = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < width) q[i] = 1'b1;
      end
      return q;
   endfunction

endpackage

// File: rtl/nr_step.sv
// nr_step: one combinational non-restoring row on a WIDTH+1-bit partial
// remainder; shifts in the next dividend bit and emits one quotient bit.
module nr_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   p_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH:0]   p_out,
   output logic [WIDTH-1:0] q_out
);
   logic [WIDTH:0] shifted;

   assign shifted = {p_in[WIDTH-1:0], q_in[WIDTH-1]};
   assign p_out   = p_in[WIDTH] ? (shifted + {1'b0, d}) : (shifted - {1'b0, d});
   assign q_out   = {q_in[WIDTH-2:0], ~p_out[WIDTH]};

endmodule

// File: rtl/divider_nr_seq.sv
// divider_nr_seq: sequential non-restoring divider, UNROLL steps per clock.
// Define DIVIDER_SIGNED_EN to honour is_signed (two's-complement operands).
//
// state | meaning
// IDLE  | waiting for operands, in_ready high; first step row runs on accept
// ITER  | UNROLL non-restoring steps per cycle
// FIX   | remainder correction and sign restore
// DONE  | result held until out_ready
module divider_nr_seq
   import divider_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int N  = WIDTH / UNROLL;
   localparam int CW = $clog2(N + 1);
   localparam logic [WIDTH-1:0] DBZ_Q    = WIDTH'(dbz_quotient(WIDTH));
   localparam logic [CW-1:0]    CNT_LOAD = CW'(N);
   localparam logic [CW-1:0]    CNT_LAST = CW'(2);

   if (WIDTH < 2 || WIDTH > 64 || (WIDTH % UNROLL) != 0) begin : g_bad_param
      $error("divider_nr_seq: WIDTH must be 2..64 and a multiple of UNROLL");
   end

   div_state_e       state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   prem;
   logic [WIDTH-1:0] qreg, dreg;
   logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix, rem_u;
   logic [WIDTH-1:0] d_step;
   logic             dbz_in, accept;
   logic [WIDTH:0]   p_ch [UNROLL+1];
   logic [WIDTH-1:0] q_ch [UNROLL+1];

   assign dbz_in    = (divisor == '0);
   assign accept    = (state == IDLE) && in_valid;
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

`ifdef DIVIDER_SIGNED_EN
   logic a_neg, b_neg, q_neg, r_neg;

   assign a_neg = is_signed & dividend[WIDTH-1];
   assign b_neg = is_signed & divisor[WIDTH-1];
   assign a_mag = a_neg ? -dividend : dividend;
   assign b_mag = b_neg ? -divisor  : divisor;
   assign q_fix = q_neg ? -qreg  : qreg;
   assign r_fix = r_neg ? -rem_u : rem_u;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (accept && !dbz_in) begin
         q_neg <= a_neg ^ b_neg;
         r_neg <= a_neg;
      end
   end
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign a_mag = dividend;
   assign b_mag = divisor;
   assign q_fix = qreg;
   assign r_fix = rem_u;
`endif

   // Low WIDTH bits of the corrected remainder; the sign bit is known zero.
   assign rem_u = prem[WIDTH] ? (prem[WIDTH-1:0] + dreg) : prem[WIDTH-1:0];

   assign p_ch[0] = (state == IDLE) ? '0    : prem;
   assign q_ch[0] = (state == IDLE) ? a_mag : qreg;
   assign d_step  = (state == IDLE) ? b_mag : dreg;

   for (genvar u = 0; u < UNROLL; u++) begin : g_row
      nr_step #(.WIDTH(WIDTH)) u_step (
         .p_in  (p_ch[u]),
         .q_in  (q_ch[u]),
         .d     (d_step),
         .p_out (p_ch[u+1]),
         .q_out (q_ch[u+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (in_valid) state_nx = dbz_in ? DONE : ((N == 1) ? FIX : ITER);
         ITER: if (cnt == CNT_LAST) state_nx = FIX;
         FIX:  state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         prem        <= '0;
         qreg        <= '0;
         dreg        <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               if (dbz_in) begin
                  quotient    <= DBZ_Q;
                  remainder   <= dividend;
                  div_by_zero <= 1'b1;
               end else begin
                  cnt         <= CNT_LOAD;
                  prem        <= p_ch[UNROLL];
                  qreg        <= q_ch[UNROLL];
                  dreg        <= b_mag;
                  div_by_zero <= 1'b0;
               end
            end
            ITER: begin
               cnt  <= cnt - 1'b1;
               prem <= p_ch[UNROLL];
               qreg <= q_ch[UNROLL];
            end
            FIX: begin
               quotient  <= q_fix;
               remainder <= r_fix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_nr_seq.sv
// tb_divider_nr_seq: randomized scoreboard bench for divider_nr_seq (8/1) plus
// directed checks on a 16-bit, 4-steps-per-clock instance.
module tb_divider_nr_seq;

`ifdef DIVIDER_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      bit         dbz;
      int         acc;
      int         lat;
   } exp_t;

   logic       clk, rst;
   logic       in_valid, in_ready, is_signed, out_valid, out_ready, div_by_zero;
   logic [7:0] dividend, divisor, quotient, remainder;

   logic        d16_in_valid, d16_in_ready, d16_out_valid, d16_dbz;
   logic [15:0] d16_dividend, d16_divisor, d16_quotient, d16_remainder;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   ready_mode = 1;
   bit   seen = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   divider_nr_seq #(.WIDTH(8), .UNROLL(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
      .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
      .remainder(remainder), .div_by_zero(div_by_zero)
   );

   divider_nr_seq #(.WIDTH(16), .UNROLL(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
      .dividend(d16_dividend), .divisor(d16_divisor), .is_signed(1'b0),
      .out_valid(d16_out_valid), .out_ready(1'b1), .quotient(d16_quotient),
      .remainder(d16_remainder), .div_by_zero(d16_dbz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer division semantics.
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input bit s, input int acc);
      exp_t   e;
      longint sa, sb, q, r;
      e.acc = acc;
      if (b == 8'd0) begin
         e.q = 8'hFF; e.r = a; e.dbz = 1'b1; e.lat = 1;
      end else begin
         if (SIGNED_EN && s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'(a);
            sb = longint'(b);
         end
         q = sa / sb;
         r = sa % sb;
         e.q = q[7:0]; e.r = r[7:0]; e.dbz = 1'b0; e.lat = 9;
      end
      return e;
   endfunction

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares every DONE cycle against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            mon_e = exp_q[0];
            if (!seen) begin
               chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
               seen = 1'b1;
            end
            chk("quotient", quotient, mon_e.q);
            chk("remainder", remainder, mon_e.r);
            chk("div_by_zero", div_by_zero, mon_e.dbz);
            chk("in_ready_in_done", in_ready, 0);
            if (out_ready) begin
               void'(exp_q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit s);
      int n = 0;
      @(negedge clk);
      dividend = a; divisor = b; is_signed = s; in_valid = 1'b1;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(model(a, b, s, cyc + 1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b);
      int          n = 0;
      int          acc;
      logic [15:0] eq, er;
      eq = (b == 16'd0) ? 16'hFFFF : (a / b);
      er = (b == 16'd0) ? a : (a % b);
      @(negedge clk);
      d16_dividend = a; d16_divisor = b; d16_in_valid = 1'b1;
      while (!d16_in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      acc = cyc + 1;
      @(posedge clk); #1;
      d16_in_valid = 1'b0;
      n = 0;
      while (!d16_out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("w16_latency", cyc - acc + 1, (b == 16'd0) ? 1 : 5);
      chk("w16_quotient", d16_quotient, eq);
      chk("w16_remainder", d16_remainder, er);
      chk("w16_div_by_zero", d16_dbz, (b == 16'd0) ? 1 : 0);
   endtask

   initial begin
      int n;
      logic [7:0] a, b;
      rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;
      d16_in_valid = 1'b0; d16_dividend = '0; d16_divisor = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_div_by_zero", div_by_zero, 0);
      rst = 1'b0;

      issue(8'd200, 8'd7, 1'b0);
      issue(8'd55, 8'd0, 1'b0);
      issue(8'hF9, 8'h02, 1'b0);
      if (SIGNED_EN) begin
         issue(8'hF9, 8'h02, 1'b1);
         issue(8'h80, 8'hFF, 1'b1);
         issue(8'h07, 8'hFE, 1'b1);
      end
      drain();

      // Stall in DONE for several cycles, then release.
      ready_mode = 2;
      issue(8'd100, 8'd9, 1'b0);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("stall_reached_done", out_valid, 1);
      repeat (5) @(negedge clk);
      ready_mode = 1;
      n = 0;
      while (!(out_valid && out_ready) && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("idle_after_handshake", {in_ready, out_valid}, 2'b10);

      // Abort in the 4th ITER cycle.
      issue(8'd200, 8'd7, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_quotient", quotient, 0);
      chk("abort_remainder", remainder, 0);
      chk("abort_div_by_zero", div_by_zero, 0);
      rst = 1'b0;
      issue(8'd9, 8'd3, 1'b0);
      drain();

      ready_mode = 0;
      for (int i = 0; i < 150; i++) begin
         a = 8'($urandom);
         case ($urandom_range(0, 9))
            0:       b = 8'd0;
            1:       b = 8'($urandom_range(1, 3));
            2:       begin a = 8'h80; b = 8'hFF; end
            default: b = 8'($urandom);
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(a, b, 1'($urandom));
      end
      drain();
      ready_mode = 1;

      run16(16'd65535, 16'd255);
      run16(16'd1234, 16'd0);
      for (int i = 0; i < 10; i++) begin
         run16(16'($urandom), 16'($urandom_range(1, 65535)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
